// File: rtl/pc_btb_fetch.sv
// pc_btb_fetch: fetch PC register with BTB next-PC prediction and E-stage redirect.
// Define BTB_STATS_EN to add the BTBHits_o/Redirects_o counters.
module pc_btb_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCen_i,
  input  logic                  RedirectE_i,
  input  logic [DATA_WIDTH-1:0] RedirectPCE_i,
  input  logic                  BranchE_i,
  input  logic                  TakenE_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
`ifdef BTB_STATS_EN
  output logic [31:0]           BTBHits_o,
  output logic [31:0]           Redirects_o,
`endif
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] PCPlus4F_o,
  output logic                  PredTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW = DATA_WIDTH - IDX - 2;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TW-1:0] tag_q [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [BTB_ENTRIES];
  logic [1:0] ctr_q [BTB_ENTRIES];
  logic [IDX-1:0] idx_f, idx_e;
  logic [TW-1:0] tag_f, tag_e;
  logic hit_f, hit_e;
  logic [1:0] ctr_e, ctr_d;
  logic unused;
  assign unused = ^PCE_i[1:0];
  assign idx_f = pc_q[IDX+1:2];
  assign tag_f = pc_q[DATA_WIDTH-1:IDX+2];
  assign idx_e = PCE_i[IDX+1:2];
  assign tag_e = PCE_i[DATA_WIDTH-1:IDX+2];
  assign hit_f = valid_q[idx_f] && tag_q[idx_f] == tag_f;
  assign hit_e = valid_q[idx_e] && tag_q[idx_e] == tag_e;
  assign ctr_e = ctr_q[idx_e];
  assign PCF_o = pc_q;
  assign PCPlus4F_o = pc_q + DATA_WIDTH'(4);
  assign PredTakenF_o = hit_f && ctr_q[idx_f][1];
  assign PredTargetF_o = PredTakenF_o ? target_q[idx_f] : PCPlus4F_o;
  always_comb begin
    pc_d = RedirectE_i ? RedirectPCE_i : PCen_i ? PredTargetF_o : pc_q;
    ctr_d = !hit_e ? 2'b10 :
            TakenE_i ? (ctr_e == 2'b11 ? ctr_e : ctr_e + 2'b01) :
            (ctr_e == 2'b00 ? ctr_e : ctr_e - 2'b01);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
      valid_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (BranchE_i && TakenE_i) valid_q[idx_e] <= 1'b1;
    end
  end
  // Entry payload needs no reset: it is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (BranchE_i && (hit_e || TakenE_i)) begin
      ctr_q[idx_e] <= ctr_d;
      if (TakenE_i) begin
        tag_q[idx_e] <= tag_e;
        target_q[idx_e] <= PCTargetE_i;
      end
    end
  end
`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BTBHits_o <= '0;
      Redirects_o <= '0;
    end else begin
      if (PCen_i && !RedirectE_i && hit_f) BTBHits_o <= BTBHits_o + 32'd1;
      if (RedirectE_i) Redirects_o <= Redirects_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_btb_fetch.sv
// tb_pc_btb_fetch: directed self-checking bench for pc_btb_fetch (RESET_VECTOR=0x100, 16 entries).
module tb_pc_btb_fetch;
  logic clk, rst, pcen, redir, branch, taken;
  logic [31:0] redir_pc, pce, pct, pcf, pcp4, ptgt;
  logic pt;
`ifdef BTB_STATS_EN
  logic [31:0] hits, redirs;
`endif
  int checks = 0;
  int failures = 0;
  pc_btb_fetch #(.DATA_WIDTH(32), .BTB_ENTRIES(16), .RESET_VECTOR(32'h100)) dut (
    .clk(clk), .rst(rst), .PCen_i(pcen), .RedirectE_i(redir), .RedirectPCE_i(redir_pc),
    .BranchE_i(branch), .TakenE_i(taken), .PCE_i(pce), .PCTargetE_i(pct),
`ifdef BTB_STATS_EN
    .BTBHits_o(hits), .Redirects_o(redirs),
`endif
    .PCF_o(pcf), .PCPlus4F_o(pcp4), .PredTakenF_o(pt), .PredTargetF_o(ptgt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [31:0] pc);
    redir = 1'b1;
    redir_pc = pc;
    step();
    redir = 1'b0;
  endtask
  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    branch = 1'b1;
    taken = tk;
    pce = pc;
    pct = tgt;
    step();
    branch = 1'b0;
  endtask
  initial begin
    rst = 1'b1; pcen = 1'b0; redir = 1'b0; branch = 1'b0; taken = 1'b0;
    redir_pc = '0; pce = '0; pct = '0;
    #3;
    chk("rst_pc", pcf, 32'h100);
    chk("rst_pt", {31'd0, pt}, 32'd0);
    chk("rst_ptgt", ptgt, 32'h104);
    step();
    rst = 1'b0;
    pcen = 1'b1;
    repeat (3) step();
    chk("seq_pc", pcf, 32'h10c);
    pcen = 1'b0;
    repeat (2) step();
    chk("stall_pc", pcf, 32'h10c);
    redirect(32'h400);
    chk("flush_pc", pcf, 32'h400);
    update(32'h108, 1'b1, 32'h200);
    redirect(32'h108);
    chk("alloc_pt", {31'd0, pt}, 32'd1);
    chk("alloc_tgt", ptgt, 32'h200);
    pcen = 1'b1;
    step();
    chk("pred_next", pcf, 32'h200);
    pcen = 1'b0;
    redirect(32'h108);
    update(32'h108, 1'b1, 32'h200);
    update(32'h108, 1'b1, 32'h200);
    chk("sat_pt", {31'd0, pt}, 32'd1);
    update(32'h108, 1'b0, 32'h600);
    chk("dec1_pt", {31'd0, pt}, 32'd1);
    chk("dec1_tgt", ptgt, 32'h200);
    update(32'h108, 1'b0, 32'h600);
    chk("dec2_pt", {31'd0, pt}, 32'd0);
    chk("dec2_tgt", ptgt, 32'h10c);
    pcen = 1'b1;
    step();
    chk("nt_next", pcf, 32'h10c);
    pcen = 1'b0;
    update(32'h300, 1'b0, 32'h700);
    redirect(32'h300);
    chk("miss_nt_pt", {31'd0, pt}, 32'd0);
    redirect(32'h108);
    branch = 1'b1; taken = 1'b1; pce = 32'h108; pct = 32'h200;
    #1;
    chk("same_old_pt", {31'd0, pt}, 32'd0);
    step();
    branch = 1'b0;
    chk("same_new_pt", {31'd0, pt}, 32'd1);
    update(32'h148, 1'b1, 32'h500);
    chk("alias_miss", {31'd0, pt}, 32'd0);
    chk("alias_miss_tgt", ptgt, 32'h10c);
    redirect(32'h148);
    chk("alias_hit_tgt", ptgt, 32'h500);
    redirect(32'hffff_fffc);
    chk("wrap_p4", pcp4, 32'h0);
    pcen = 1'b1;
    step();
    chk("wrap_pc", pcf, 32'h0);
    pcen = 1'b0;
    redirect(32'h240);
    chk("mid_pc", pcf, 32'h240);
    branch = 1'b1; taken = 1'b1; pce = 32'h240; pct = 32'h800;
    #2 rst = 1'b1;
    #1;
    chk("async_pc", pcf, 32'h100);
    chk("async_pt", {31'd0, pt}, 32'd0);
    step();
    branch = 1'b0;
    rst = 1'b0;
    pcen = 1'b1;
    step();
    chk("rel_pc", pcf, 32'h104);
    pcen = 1'b0;
    redirect(32'h240);
    chk("cleared_pt", {31'd0, pt}, 32'd0);
    update(32'h108, 1'b1, 32'h200);
    update(32'h200, 1'b1, 32'h108);
    redirect(32'h108);
    pcen = 1'b1;
    repeat (3) step();
    pcen = 1'b0;
    chk("loop_pc", pcf, 32'h200);
`ifdef BTB_STATS_EN
    chk("stat_hits", hits, 32'd3);
    chk("stat_redirs", redirs, 32'd2);
    rst = 1'b1;
    #1;
    chk("stat_hits_rst", hits, 32'd0);
    chk("stat_redirs_rst", redirs, 32'd0);
    rst = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_btb_fetch.md
Name: pc_btb_fetch

Overview:
Parametrised fetch-stage PC unit for the pipelined core.
- Keeps the existing PC register, PC+4 and stall-enable behaviour.
- Adds a configurable reset vector, a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and a single E-stage redirect path.
- Predicts next PC in F from the BTB. Downstream logic compares the prediction and asserts a redirect on mismatch.

Parameters:
DATA_WIDTH, 32, width of PC and targets
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2
RESET_VECTOR, 32'h0, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
PCen_i  input  1  fetch enable; low = stall (hold PC)
RedirectE_i  input  1  E-stage correction valid (mispredict/jalr)
RedirectPCE_i  input  DATA_WIDTH  correct next PC when RedirectE_i=1
BranchE_i  input  1  E-stage instr is branch/jal; triggers BTB update
TakenE_i  input  1  resolved outcome of the E-stage branch
PCE_i  input  DATA_WIDTH  PC of the E-stage branch
PCTargetE_i  input  DATA_WIDTH  resolved taken target of the E-stage branch
PCF_o  output  DATA_WIDTH  current fetch PC
PCPlus4F_o  output  DATA_WIDTH  PCF_o + 4, modulo 2^DATA_WIDTH
PredTakenF_o  output  1  BTB predicts taken for PCF_o
PredTargetF_o  output  DATA_WIDTH  predicted next PC (BTB target if PredTakenF_o, else PCPlus4F_o)

Behaviour:
- IDX = log2(BTB_ENTRIES). Index = PC[IDX+1:2]. Tag = PC[DATA_WIDTH-1:IDX+2]. PC[1:0] is ignored.
- Each entry holds: valid, tag, target[DATA_WIDTH-1:0], ctr[1:0].
- Reset (async, any time, including mid-update):
  - PCF_o = RESET_VECTOR
  - all valid bits = 0; tag/target/ctr are don't-care
  - PredTakenF_o = 0 and PredTargetF_o = RESET_VECTOR+4 while in reset
  - after deassertion, first edge behaves normally
- Lookup (combinational on PCF_o): hit = valid[idx] & tag match. PredTakenF_o = hit & ctr[1].
- Next-PC priority at each rising edge:
  1. RedirectE_i=1 -> RedirectPCE_i. Applies even when PCen_i=0 (flush beats stall).
  2. PCen_i=0 -> hold PCF_o.
  3. otherwise -> PredTargetF_o.
- BTB update at the rising edge when BranchE_i=1, independent of PCen_i and RedirectE_i:
  - Hit on PCE_i, TakenE_i=1: ctr = min(ctr+1, 3); target = PCTargetE_i.
  - Hit on PCE_i, TakenE_i=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss, TakenE_i=1: allocate/overwrite the entry: valid=1, tag, target=PCTargetE_i, ctr=2'b10.
  - Miss, TakenE_i=0: no change.
- Same-cycle lookup and update of the same index: lookup sees pre-update contents. The new contents are visible from the next cycle; no bypass.
- Latency: prediction 0 cycles (same cycle as PCF_o); BTB write visible 1 cycle later; redirect changes PCF_o 1 edge after assertion.
- PC arithmetic wraps: PCF_o = all-ones-minus-3 gives PCPlus4F_o = 0.
- Implementation: BTB is register-based (no RAM macro), because async reset of the valid bits is required.

Optional Feature:
BTB_STATS_EN
- Defined: adds outputs BTBHits_o (32) and Redirects_o (32), both wrapping, both reset to 0 by rst.
  - BTBHits_o increments on each edge where PCen_i=1, RedirectE_i=0 and hit=1.
  - Redirects_o increments on each edge where RedirectE_i=1.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: RESET_VECTOR=32'h100, rst pulsed mid-run with PC=0x240 -> PCF_o=0x100 immediately (async), PredTakenF_o=0; first edge after release -> 0x104.
- Sequential/stall: PCen_i=1 for 3 edges from 0x100 -> 0x10C; PCen_i=0 for 2 edges -> holds 0x10C; PCen_i=0 with RedirectE_i=1, RedirectPCE_i=0x400 -> PCF_o=0x400 next edge.
- Allocate/predict: BranchE_i=1, TakenE_i=1, PCE_i=0x108, PCTargetE_i=0x200 -> next time PCF_o=0x108: PredTakenF_o=1, PredTargetF_o=0x200, next PC 0x200.
- Counter saturation: two further taken updates on 0x108 (ctr=3), then two not-taken updates -> ctr=1, PredTakenF_o=0 at 0x108, next PC 0x10C; one not-taken on a miss PC 0x300 -> no allocation.
- Alias/same-cycle: BTB_ENTRIES=16, entry for 0x108 valid; taken update at 0x148 (same index, different tag) -> replaces entry, 0x108 now misses. Update and lookup to the same index in one cycle -> lookup returns old prediction.
- Stats (BTB_STATS_EN): 3 predicted hits, 2 redirects -> BTBHits_o=3, Redirects_o=2; rst -> both 0.
